// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
package ccff_chain_loader_pkg;

  localparam int DEFAULT_CHAIN_LEN = 64;
  localparam int DEFAULT_WORD_W    = 8;

  typedef logic [1:0] ccff_state_t;

  localparam ccff_state_t ST_IDLE  = 2'd0;
  localparam ccff_state_t ST_LOAD  = 2'd1;
  localparam ccff_state_t ST_SHIFT = 2'd2;
  localparam ccff_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ccff_word_piso.sv
// Parallel-load, MSB-first shift register; count_o reports bits shifted out since the last load.
module ccff_word_piso #(
  parameter int WORD_W = 8,
  localparam int CNT_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              msb_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o   = sr_q[WORD_W-1];
  assign count_o = cnt_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into a CHAIN_LEN-stage p_ccff chain.
// Optional tail readback is built when CCFF_CHAIN_LOADER_READBACK_EN is defined.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  ,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
`endif
);

  localparam int BC_W = $clog2(CHAIN_LEN + 1);
  localparam int PC_W = $clog2(WORD_W + 1);

  ccff_state_t     state_q, state_d;
  logic [BC_W-1:0] bits_q, bits_d;

  logic            piso_msb;
  logic [PC_W-1:0] piso_cnt;
  logic            handshake;
  logic            chain_end;
  logic            word_end;

  assign handshake = (state_q == ST_LOAD) && wr_valid;
  assign chain_end = (bits_q == BC_W'(CHAIN_LEN - 1));
  // A word ends at its last bit or at the chain's last bit, whichever comes first.
  assign word_end  = (piso_cnt == PC_W'(WORD_W - 1)) || chain_end;

  ccff_word_piso #(.WORD_W(WORD_W)) u_piso (
    .clk     (prog_clk),
    .srst    (prog_reset),
    .load_i  (handshake),
    .shift_i (ccff_shift_en),
    .data_i  (wr_data),
    .msb_o   (piso_msb),
    .count_o (piso_cnt)
  );

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          bits_d  = '0;
        end
      end
      ST_LOAD: begin
        if (wr_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        bits_d = bits_q + BC_W'(1);
        if (word_end) state_d = chain_end ? ST_DONE : ST_LOAD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= ST_IDLE;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
    end
  end

  assign wr_ready      = (state_q == ST_LOAD);
  assign ccff_shift_en = (state_q == ST_SHIFT);
  assign ccff_head     = ccff_shift_en & piso_msb;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [WORD_W-1:0] cap_q, cap_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Capture position tracks the outgoing word's bit count, so words stay left-aligned.
  always_comb begin
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (ccff_shift_en) begin
      cap_d = cap_q | (WORD_W'(ccff_tail) << (WORD_W - 1 - 32'(piso_cnt)));
      if (word_end) begin
        rd_data_d  = cap_d;
        rd_valid_d = 1'b1;
        cap_d      = '0;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (20- and 5-stage chains) driven into behavioural chain models.
module tb_ccff_chain_loader;

  localparam int WW = 8;
  localparam int NA = 20;
  localparam int NB = 5;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic          prog_reset = 1'b1;
  logic          start = 1'b0;
  logic          sel5 = 1'b0;
  logic          wr_valid = 1'b0;
  logic [WW-1:0] wr_data = '0;

  logic start_a, wr_valid_a, start_b, wr_valid_b;
  assign start_a    = start & ~sel5;
  assign wr_valid_a = wr_valid & ~sel5;
  assign start_b    = start & sel5;
  assign wr_valid_b = wr_valid & sel5;

  logic wr_ready_a, head_a, sh_a, tail_a, busy_a, done_a;
  logic wr_ready_b, head_b, sh_b, tail_b, busy_b, done_b;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [WW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic [WW-1:0] rdq_a[$];
  logic [WW-1:0] rdq_b[$];
`endif

  logic [NA-1:0] chain_a = '0;
  logic [NB-1:0] chain_b = '0;
  assign tail_a = chain_a[NA-1];
  assign tail_b = chain_b[NB-1];

  int shifts_a = 0, dones_a = 0, hs_a = 0;
  int shifts_b = 0, dones_b = 0, hs_b = 0;
  int vectors = 0, errors = 0;
  logic [WW-1:0] wq [0:3];

  ccff_chain_loader #(.CHAIN_LEN(NA), .WORD_W(WW)) dut_a (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start_a),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid_a),
    .wr_ready      (wr_ready_a),
    .ccff_head     (head_a),
    .ccff_shift_en (sh_a),
    .ccff_tail     (tail_a),
    .busy          (busy_a),
    .done          (done_a)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    ,
    .rd_data       (rd_data_a),
    .rd_valid      (rd_valid_a)
`endif
  );

  ccff_chain_loader #(.CHAIN_LEN(NB), .WORD_W(WW)) dut_b (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start_b),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid_b),
    .wr_ready      (wr_ready_b),
    .ccff_head     (head_b),
    .ccff_shift_en (sh_b),
    .ccff_tail     (tail_b),
    .busy          (busy_b),
    .done          (done_b)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    ,
    .rd_data       (rd_data_b),
    .rd_valid      (rd_valid_b)
`endif
  );

  // Behavioural chains: stage 0 takes the head, the last stage is the tail.
  always @(posedge prog_clk) begin
    if (sh_a) begin
      chain_a  <= {chain_a[NA-2:0], head_a};
      shifts_a <= shifts_a + 1;
    end
    if (done_a) dones_a <= dones_a + 1;
    if (wr_valid_a && wr_ready_a) hs_a <= hs_a + 1;
    if (sh_b) begin
      chain_b  <= {chain_b[NB-2:0], head_b};
      shifts_b <= shifts_b + 1;
    end
    if (done_b) dones_b <= dones_b + 1;
    if (wr_valid_b && wr_ready_b) hs_b <= hs_b + 1;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    if (rd_valid_a) rdq_a.push_back(rd_data_a);
    if (rd_valid_b) rdq_b.push_back(rd_data_b);
`endif
  end

  logic wr_ready_s, sh_s, busy_s;
  assign wr_ready_s = sel5 ? wr_ready_b : wr_ready_a;
  assign sh_s       = sel5 ? sh_b : sh_a;
  assign busy_s     = sel5 ? busy_b : busy_a;

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected chain: the bitstream (words MSB-first) truncated to n bits; first bit ends at the tail.
  function automatic logic [63:0] ref_chain(input int n);
    logic [63:0]   r;
    logic [WW-1:0] w;
    r = '0;
    for (int i = 0; i < n; i++) begin
      w = wq[i / WW];
      r = (r << 1) | 64'(w[WW-1-(i % WW)]);
    end
    return r;
  endfunction

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  // Readback word k: chain bits in exit order (tail first), left-aligned, zero padded.
  function automatic logic [WW-1:0] ref_rd(input logic [63:0] snap, input int n, input int k);
    logic [WW-1:0] w;
    int idx;
    w = '0;
    for (int b = 0; b < WW; b++) begin
      idx = k * WW + b;
      if (idx < n) w[WW-1-b] = snap[n-1-idx];
    end
    return w;
  endfunction
`endif

  task automatic run_load(input bit use5, input int nw, input int stall_at,
                          input int stall_len, input bit poke);
    int          n, c, base_sh, base_dn, base_hs;
    bit          acc;
    logic [63:0] snap, got;
    n       = use5 ? NB : NA;
    snap    = use5 ? 64'(chain_b) : 64'(chain_a);
    base_sh = use5 ? shifts_b : shifts_a;
    base_dn = use5 ? dones_b : dones_a;
    base_hs = use5 ? hs_b : hs_a;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    rdq_a.delete();
    rdq_b.delete();
`endif
    sel5  = use5;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 64'(busy_s), 64'd1);
    for (int w = 0; w < nw; w++) begin
      if (w == stall_at && stall_len > 0) begin
        c = 0;
        while (!wr_ready_s && c < 100) begin
          step();
          c++;
        end
        for (int k = 0; k < stall_len; k++) begin
          start = poke && (k == 0);
          check("stall_no_shift", 64'({sh_s, wr_ready_s}), 64'd1);
          step();
          start = 1'b0;
        end
      end
      wr_valid = 1'b1;
      wr_data  = wq[w];
      acc = 1'b0;
      c   = 0;
      while (!acc && c < 200) begin
        acc = wr_ready_s;
        step();
        c++;
      end
      wr_valid = 1'b0;
      check("word_accepted", 64'(acc), 64'd1);
      if (poke && w == 0) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    c = 0;
    while (busy_s && c < 200) begin
      step();
      c++;
    end
    step();
    got = use5 ? 64'(chain_b) : 64'(chain_a);
    check("chain_content", got, ref_chain(n));
    check("shift_count", 64'((use5 ? shifts_b : shifts_a) - base_sh), 64'(n));
    check("done_pulses", 64'((use5 ? dones_b : dones_a) - base_dn), 64'd1);
    check("word_requests", 64'((use5 ? hs_b : hs_a) - base_hs), 64'(nw));
    check("idle_after_done", 64'(busy_s), 64'd0);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    check("rd_count", 64'(use5 ? rdq_b.size() : rdq_a.size()), 64'((n + WW - 1) / WW));
    for (int k = 0; k < (n + WW - 1) / WW; k++) begin
      got = use5 ? 64'(k < rdq_b.size() ? rdq_b[k] : 8'hxx)
                 : 64'(k < rdq_a.size() ? rdq_a[k] : 8'hxx);
      check("rd_word", got, 64'(ref_rd(snap, n, k)));
    end
`endif
  endtask

  initial begin
    int c, base_sh, base_dn;
    bit acc;

    repeat (3) step();
    check("reset_a", 64'({wr_ready_a, head_a, sh_a, busy_a, done_a}), 64'd0);
    check("reset_b", 64'({wr_ready_b, head_b, sh_b, busy_b, done_b}), 64'd0);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    check("reset_rd", 64'({rd_valid_a, rd_data_a, rd_valid_b, rd_data_b}), 64'd0);
`endif
    prog_reset = 1'b0;
    step();

    // Three words, valid held high; last word truncated to its top nibble.
    wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hF0;
    run_load(1'b0, 3, -1, 0, 1'b0);
    check("s44_chain", 64'(chain_a), 64'h0A53CF);

    // Five stall cycles in LOAD before the second word.
    run_load(1'b0, 3, 1, 5, 1'b0);
    check("s45_chain", 64'(chain_a), 64'h0A53CF);

    // start pulsed during SHIFT and LOAD must not restart the load.
    run_load(1'b0, 3, 1, 3, 1'b1);
    check("s47_chain", 64'(chain_a), 64'h0A53CF);

    // Chain shorter than a word.
    wq[0] = 8'hB8;
    run_load(1'b1, 1, -1, 0, 1'b0);
    check("s47_short_chain", 64'(chain_b), 64'h17);

    // Reset on the third SHIFT cycle aborts the load.
    sel5    = 1'b0;
    base_sh = shifts_a;
    base_dn = dones_a;
    start   = 1'b1;
    step();
    start    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    acc = 1'b0;
    c   = 0;
    while (!acc && c < 50) begin
      acc = wr_ready_a;
      step();
      c++;
    end
    wr_valid = 1'b0;
    check("abort_word_accepted", 64'(acc), 64'd1);
    step();
    step();
    check("abort_third_shift", 64'(sh_a), 64'd1);
    prog_reset = 1'b1;
    step();
    prog_reset = 1'b0;
    check("abort_outputs", 64'({wr_ready_a, head_a, sh_a, busy_a, done_a}), 64'd0);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    check("abort_rd", 64'({rd_valid_a, rd_data_a}), 64'd0);
`endif
    repeat (5) step();
    check("abort_shift_count", 64'(shifts_a - base_sh), 64'd3);
    check("abort_no_done", 64'(dones_a - base_dn), 64'd0);
    check("abort_stays_idle", 64'({busy_a, sh_a}), 64'd0);

    // Randomized loads against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) wq[i] = 8'($urandom);
      run_load(1'b0, 3, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'($urandom));
    end
    for (int r = 0; r < 3; r++) begin
      wq[0] = 8'($urandom);
      run_load(1'b1, 1, 0, int'($urandom_range(0, 4)), 1'($urandom));
    end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    // Reload zeros after a known load: readback returns the previous content.
    wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hF0;
    run_load(1'b0, 3, -1, 0, 1'b0);
    wq[0] = 8'h00; wq[1] = 8'h00; wq[2] = 8'h00;
    run_load(1'b0, 3, -1, 0, 1'b0);
    check("s48_rd_count", 64'(rdq_a.size()), 64'd3);
    if (rdq_a.size() == 3) begin
      check("s48_rd0", 64'(rdq_a[0]), 64'hA5);
      check("s48_rd1", 64'(rdq_a[1]), 64'h3C);
      check("s48_rd2", 64'(rdq_a[2]), 64'hF0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
